mau_result_collector: RTL
=========================

// Module: mau_result_collector
// PURPOSE
//   Receive end of the weight-stationary systolic mesh. Captures the per-column
//   acc_out / out_image_load streams leaving the bottom MAU row (column c lags
//   column 0 by c cycles), deskews them into one aligned result row, buffers
//   rows in a small FIFO, and hands them downstream on a valid/ready interface.
//   The mesh cannot stall, so upstream has no backpressure; overflow is flagged.
// PARAMETERS
//   mesh_length  4   columns in the mesh (>=2)
//   acc_length   32  signed accumulator width per column
//   FIFO_DEPTH   4   aligned rows buffered (power of 2, >=2)
// PORTS
//   clk          in   1                        clock, rising edge
//   rst_n        in   1                        async reset, active low
//   flush        in   1                        sync clear of deskew lines + FIFO
//   col_valid    in   mesh_length              out_image_load of bottom PE, bit c = column c
//   col_acc      in   acc_length*mesh_length   acc_out of bottom PE, column c at [c*acc_length +: acc_length]
//   row_valid    out  1                        aligned row available
//   row_ready    in   1                        downstream accepts row
//   row_data     out  acc_length*mesh_length   aligned row, same column packing
//   fifo_count   out  $clog2(FIFO_DEPTH)+1     rows held
//   err_skew     out  1                        sticky: partially valid aligned row seen
//   err_ovf      out  1                        sticky: row dropped, FIFO full
// BEHAVIOUR
//   - Reset: single clock clk; reset rst_n is asynchronous, active low. All
//     outputs 0; deskew regs, FIFO pointers, sticky flags cleared.
//   - Deskew: column c passes through (mesh_length-1-c) registered stages
//     (valid+data); column mesh_length-1 is used directly. The aligned vector
//     is combinational from the last stage of each column.
//   - Push: at the edge where all aligned valids are 1, the row is written into
//     the FIFO. Back-to-back rows (col 0 valid on consecutive cycles) sustained
//     at 1 row/cycle.
//   - Aligned valid non-zero but not all-ones: row discarded, err_skew set.
//   - Full and no pop that cycle: row discarded, err_ovf set, contents unchanged.
//   - Full with simultaneous pop: push succeeds, fifo_count unchanged.
//   - Latency: last column (mesh_length-1) valid sampled at edge k -> row_valid=1
//     after edge k (first-word-fall-through, row_data registered from FIFO head).
//   - Handshake: pop on row_valid&&row_ready. row_data stable while
//     row_valid&&!row_ready. row_valid never drops without a pop (except flush
//     or reset). Pop when empty: no effect.
//   - flush: at that edge clears deskew stages, FIFO, row_valid, fifo_count;
//     push/pop that cycle ignored; sticky errors kept (reset only clears them).
//   - Reset mid-operation: all in-flight partial rows lost, no spurious row_valid.
//   - Data passed bit-exact (signed two's complement, no width change) unless
//     the optional feature below is compiled in.
// CONFIGURATION
//   COLLECTOR_RELU_EN defined: each column value with MSB=1 is replaced by 0 on
//   FIFO write (ReLU). Undefined: values passed unchanged. Flags/timing
//   identical in both builds.
// TESTING (mesh_length=4, acc_length=32, FIFO_DEPTH=4)
//   - Reset: rst_n low mid-row -> all outputs 0 after reset, no row emitted.
//   - Skewed row: col c valid at cycle t+c with acc=10,20,-5,40 -> row_valid after
//     edge t+3, row_data={40,-5,20,10}; RELU build {40,0,20,10}.
//   - Stream: 6 back-to-back rows, row_ready=1 -> 6 rows in order, no gaps,
//     no errors.
//   - Overflow: row_ready=0, 5 rows -> fifo_count=4, err_ovf=1, rows 1-4 kept in
//     order when drained.
//   - Full+pop: FIFO full, row_ready=1 as new row lands -> count stays 4, err_ovf=0.
//   - Skew fault: column 2 valid one cycle late -> err_skew=1, no row pushed;
//     flush -> count 0, err_skew stays 1.

Source files
------------

// File: rtl/mau_result_collector.sv
// Deskews the bottom-row MAU column streams into aligned rows, then buffers them in a FWFT FIFO for a valid/ready sink.
// Latency: a row whose last column is sampled at edge k shows row_valid=1 right after edge k.
// Backpressure: the mesh cannot stall, so rows are dropped when the FIFO is full (err_ovf); partial rows set err_skew. Optional ReLU: COLLECTOR_RELU_EN.
module mau_result_collector #(
  parameter int mesh_length = 4,
  parameter int acc_length  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [mesh_length-1:0]              col_valid,
  input  logic [acc_length*mesh_length-1:0]   col_acc,
  output logic                                row_valid,
  input  logic                                row_ready,
  output logic [acc_length*mesh_length-1:0]   row_data,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                err_skew,
  output logic                                err_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = acc_length * mesh_length;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  // Aligned row as seen at the output of the deskew lines.
  logic [mesh_length-1:0] al_vld;
  logic [RW-1:0]          al_dat;

  genvar c;
  generate
    for (c = 0; c < mesh_length; c++) begin : g_col
      if (c == mesh_length-1) begin : g_direct
        // The last column arrives latest, so it needs no delay.
        assign al_vld[c] = col_valid[c];
        assign al_dat[c*acc_length +: acc_length] = col_acc[c*acc_length +: acc_length];
      end else begin : g_dly
        localparam int D = mesh_length - 1 - c;
        logic [D-1:0]          v_sr;
        logic [acc_length-1:0] d_sr [D];

        // Delay column c by D cycles so it lines up with the last column.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < D; i++) d_sr[i] <= '0;
          end else if (flush) begin
            v_sr <= '0;
            for (int i = 0; i < D; i++) d_sr[i] <= '0;
          end else begin
            v_sr[0] <= col_valid[c];
            d_sr[0] <= col_acc[c*acc_length +: acc_length];
            for (int i = 1; i < D; i++) begin
              v_sr[i] <= v_sr[i-1];
              d_sr[i] <= d_sr[i-1];
            end
          end
        end

        assign al_vld[c] = v_sr[D-1];
        assign al_dat[c*acc_length +: acc_length] = d_sr[D-1];
      end
    end
  endgenerate

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          row_full, skew_hit, full, pop, push, ovf;
  logic [PW:0]   cnt_nxt;
  logic [RW-1:0] wr_dat;

  // Classify the aligned row and decide push / pop / drop for this edge.
  always_comb begin
    row_full = &al_vld;
    skew_hit = (|al_vld) && !row_full;
    full     = (fifo_count == FULL_CNT);
    pop      = row_valid && row_ready;
    push     = row_full && (!full || pop);
    ovf      = row_full && full && !pop;
    cnt_nxt  = fifo_count;
    case ({push, pop})
      2'b10:   cnt_nxt = fifo_count + 1'b1;
      2'b01:   cnt_nxt = fifo_count - 1'b1;
      default: cnt_nxt = fifo_count;
    endcase
  end

  // Write data, optionally clamped to zero for negative columns.
  always_comb begin
    wr_dat = al_dat;
`ifdef COLLECTOR_RELU_EN
    for (int i = 0; i < mesh_length; i++) begin
      if (al_dat[i*acc_length + acc_length - 1]) wr_dat[i*acc_length +: acc_length] = '0;
    end
`endif
  end

  // Row storage; the head entry is presented directly (first-word-fall-through).
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_dat;
  end

  // FIFO pointers, occupancy, output valid and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      row_valid  <= 1'b0;
      err_skew   <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      row_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= cnt_nxt;
      row_valid  <= (cnt_nxt != '0);
      if (skew_hit) err_skew <= 1'b1;
      if (ovf)      err_ovf  <= 1'b1;
    end
  end

  // Stale entries stay hidden when nothing is held.
  assign row_data = row_valid ? mem[rd_ptr] : '0;

endmodule
